// File: rtl/otter_inst_encoder.sv
// RV32I field-level request -> 32-bit instruction word encoder with a valid/ready output port.
// Define OTTER_ENC_LI_EN to enable LI pseudo-instruction expansion (kind 11, two-word LUI+ADDI).
module otter_inst_encoder (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  REQ_KIND,
  input  logic [2:0]  REQ_FUNC3,
  input  logic        REQ_FUNC7_5,
  input  logic [4:0]  REQ_RD,
  input  logic [4:0]  REQ_RS1,
  input  logic [4:0]  REQ_RS2,
  input  logic [31:0] REQ_IMM,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST_WORD,
  output logic        INST_LAST,
  output logic        BAD_REQ
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

`ifdef OTTER_ENC_LI_EN
  typedef enum logic [1:0] {IDLE, EMIT, EMIT_LI1} state_t;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif

  state_t      state_reg, state_next;
  logic [31:0] word_reg, word_next;
  logic        last_reg, last_next;
  logic        bad_reg, bad_next;

  logic [31:0] enc_first;
  logic        enc_bad;
  logic        accept;
  logic        load;

`ifdef OTTER_ENC_LI_EN
  logic [31:0] pend_reg, pend_next;
  logic [31:0] enc_second;
  logic        enc_two;
  logic [19:0] li_hi;
  logic        li_small;

  // hi is rounded up when imm[11] is set, since the ADDI sign-extends its low 12 bits
  assign li_hi    = REQ_IMM[31:12] + {19'd0, REQ_IMM[11]};
  assign li_small = (&REQ_IMM[31:11]) || (~|REQ_IMM[31:11]);
`endif

  always_comb begin
    enc_first = '0;
    enc_bad   = 1'b0;
`ifdef OTTER_ENC_LI_EN
    enc_second = '0;
    enc_two    = 1'b0;
`endif
    case (REQ_KIND)
      4'd0:  enc_first = {1'b0, REQ_FUNC7_5, 5'b0, REQ_RS2, REQ_RS1, REQ_FUNC3, REQ_RD, OP_R};
      4'd1:  enc_first = {REQ_IMM[11:0], REQ_RS1, REQ_FUNC3, REQ_RD, OP_IMM};
      4'd2:  enc_first = {1'b0, REQ_FUNC7_5, 5'b0, REQ_IMM[4:0], REQ_RS1, REQ_FUNC3, REQ_RD, OP_IMM};
      4'd3:  enc_first = {REQ_IMM[11:0], REQ_RS1, REQ_FUNC3, REQ_RD, OP_LOAD};
      4'd4:  enc_first = {REQ_IMM[11:5], REQ_RS2, REQ_RS1, REQ_FUNC3, REQ_IMM[4:0], OP_STORE};
      4'd5: begin
        enc_first = {REQ_IMM[12], REQ_IMM[10:5], REQ_RS2, REQ_RS1, REQ_FUNC3,
                     REQ_IMM[4:1], REQ_IMM[11], OP_BRANCH};
        enc_bad   = REQ_IMM[0];
      end
      4'd6:  enc_first = {REQ_IMM[31:12], REQ_RD, OP_LUI};
      4'd7:  enc_first = {REQ_IMM[31:12], REQ_RD, OP_AUIPC};
      4'd8: begin
        enc_first = {REQ_IMM[20], REQ_IMM[10:1], REQ_IMM[11], REQ_IMM[19:12], REQ_RD, OP_JAL};
        enc_bad   = REQ_IMM[0];
      end
      4'd9:  enc_first = {REQ_IMM[11:0], REQ_RS1, 3'b000, REQ_RD, OP_JALR};
      4'd10: enc_first = {REQ_IMM[11:0], REQ_RS1, REQ_FUNC3, REQ_RD, OP_SYSTEM};
`ifdef OTTER_ENC_LI_EN
      4'd11: begin
        if (li_small) begin
          enc_first = {REQ_IMM[11:0], 5'd0, 3'b000, REQ_RD, OP_IMM};
        end else if (REQ_IMM[11:0] == 12'd0) begin
          enc_first = {REQ_IMM[31:12], REQ_RD, OP_LUI};
        end else begin
          enc_first  = {li_hi, REQ_RD, OP_LUI};
          enc_second = {REQ_IMM[11:0], REQ_RD, 3'b000, REQ_RD, OP_IMM};
          enc_two    = 1'b1;
        end
      end
`endif
      default: enc_bad = 1'b1;
    endcase
  end

  assign REQ_READY = (state_reg == IDLE) || ((state_reg == EMIT) && INST_READY);
  assign accept    = REQ_VALID && REQ_READY;
  assign load      = accept && !enc_bad;

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    last_next  = last_reg;
    bad_next   = accept && enc_bad;
`ifdef OTTER_ENC_LI_EN
    pend_next  = pend_reg;
`endif
    if (load) begin
      word_next = enc_first;
`ifdef OTTER_ENC_LI_EN
      last_next  = !enc_two;
      pend_next  = enc_second;
      state_next = enc_two ? EMIT_LI1 : EMIT;
`else
      last_next  = 1'b1;
      state_next = EMIT;
`endif
    end else if (INST_READY) begin
      // illegal requests leave the output path exactly as an idle cycle would
      case (state_reg)
        EMIT: state_next = IDLE;
`ifdef OTTER_ENC_LI_EN
        EMIT_LI1: begin
          word_next  = pend_reg;
          last_next  = 1'b1;
          state_next = EMIT;
        end
`endif
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      last_reg  <= 1'b0;
      bad_reg   <= 1'b0;
`ifdef OTTER_ENC_LI_EN
      pend_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      last_reg  <= last_next;
      bad_reg   <= bad_next;
`ifdef OTTER_ENC_LI_EN
      pend_reg  <= pend_next;
`endif
    end
  end

  assign INST_VALID = (state_reg != IDLE);
  assign INST_WORD  = word_reg;
  assign INST_LAST  = last_reg;
  assign BAD_REQ    = bad_reg;

endmodule
